// File: rtl/decode_stage_if.sv
// Bus bundle for decode_stage: the fetch-side input handshake, the flush
// request and the decoded output bundle with its handshake.
//
// Handshake rule for both sides: a transfer happens on a rising clock edge
// where valid && ready are both 1. Once valid is raised, the sender holds
// valid and its payload unchanged until that transfer happens. ready may
// move freely and never depends combinationally on valid from the same side.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm;
  logic            is_alu_op;
  logic            alu_src_imm;
  logic            is_branch;
  logic            is_load;
  logic            is_store;
  logic            is_jump;
  logic            is_lui;
  logic            is_auipc;
  logic            is_muldiv;
  logic            rd_we;
  logic            illegal;

  // Fetch / downstream side.
  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, opcode, rd, funct3, rs1, rs2, funct7,
           imm, is_alu_op, alu_src_imm, is_branch, is_load, is_store, is_jump,
           is_lui, is_auipc, is_muldiv, rd_we, illegal
  );

  // Decode stage side.
  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, opcode, rd, funct3, rs1, rs2, funct7,
           imm, is_alu_op, alu_src_imm, is_branch, is_load, is_store, is_jump,
           is_lui, is_auipc, is_muldiv, rd_we, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage (optional M extension) with a two-entry skid
// buffer: a main output register plus one skid register. Decode is purely
// combinational on the incoming word and captured when the word is accepted.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input logic          clk,
  input logic          rst,
  decode_stage_if.slave bus
);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            is_alu_op;
    logic            alu_src_imm;
    logic            is_branch;
    logic            is_load;
    logic            is_store;
    logic            is_jump;
    logic            is_lui;
    logic            is_auipc;
    logic            is_muldiv;
    logic            rd_we;
    logic            illegal;
  } bundle_t;

  logic [31:0] instr;
  bundle_t     dec;
  bundle_t     main_q;
  bundle_t     skid_q;
  logic        main_v;
  logic        skid_v;
  logic        accept;
  logic        consume;

  // Immediate candidates, sign bit instr[31] replicated up to XLEN.
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  // Legality sub-terms.
  logic known_opc;
  logic r_funct7_ok;
  logic bad_branch;
  logic bad_jalr;
  logic bad_op;
  logic is_illegal;
  logic writes_rd;

  assign instr = bus.in_instr;

  assign imm_i = {{(XLEN-11){instr[31]}}, instr[30:20]};
  assign imm_s = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
  assign imm_b = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
  assign imm_j = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  // Classify the incoming word and flag encodings outside the supported map.
  always_comb begin
    known_opc   = 1'b0;
    r_funct7_ok = 1'b0;
    writes_rd   = 1'b0;
    case (instr[6:0])
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP: begin
        known_opc = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_BRANCH, OPC_STORE, OPC_MISC_MEM, OPC_SYSTEM: known_opc = 1'b1;
      default: known_opc = 1'b0;
    endcase

    case (instr[31:25])
      7'b0000000: r_funct7_ok = 1'b1;
      // Only SUB and SRA use the alternate funct7.
      7'b0100000: r_funct7_ok = (instr[14:12] == 3'b000) || (instr[14:12] == 3'b101);
      7'b0000001: r_funct7_ok = ENABLE_M;
      default:    r_funct7_ok = 1'b0;
    endcase

    bad_op     = (instr[6:0] == OPC_OP) && !r_funct7_ok;
    bad_branch = (instr[6:0] == OPC_BRANCH) &&
                 ((instr[14:12] == 3'b010) || (instr[14:12] == 3'b011));
    bad_jalr   = (instr[6:0] == OPC_JALR) && (instr[14:12] != 3'b000);
    // opcode compare covers instr[1:0] == 2'b11 as well.
    is_illegal = !known_opc || bad_op || bad_branch || bad_jalr;
  end

  // Build the decoded bundle; fields are raw slices, controls gated by legality.
  always_comb begin
    dec        = '0;
    dec.pc     = bus.in_pc;
    dec.opcode = instr[6:0];
    dec.rd     = instr[11:7];
    dec.funct3 = instr[14:12];
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.funct7 = instr[31:25];
    dec.illegal = is_illegal;
    if (!is_illegal) begin
      dec.is_alu_op   = (instr[6:0] == OPC_OP) || (instr[6:0] == OPC_OP_IMM);
      dec.alu_src_imm = (instr[6:0] == OPC_OP_IMM) || (instr[6:0] == OPC_LOAD) ||
                        (instr[6:0] == OPC_STORE)  || (instr[6:0] == OPC_JALR) ||
                        (instr[6:0] == OPC_LUI)    || (instr[6:0] == OPC_AUIPC);
      dec.is_branch   = (instr[6:0] == OPC_BRANCH);
      dec.is_load     = (instr[6:0] == OPC_LOAD);
      dec.is_store    = (instr[6:0] == OPC_STORE);
      dec.is_jump     = (instr[6:0] == OPC_JAL) || (instr[6:0] == OPC_JALR);
      dec.is_lui      = (instr[6:0] == OPC_LUI);
      dec.is_auipc    = (instr[6:0] == OPC_AUIPC);
      dec.is_muldiv   = (instr[6:0] == OPC_OP) && (instr[31:25] == 7'b0000001);
      dec.rd_we       = writes_rd && (instr[11:7] != 5'd0);
      case (instr[6:0])
        OPC_OP_IMM, OPC_LOAD, OPC_JALR: dec.imm = imm_i;
        OPC_STORE:                      dec.imm = imm_s;
        OPC_BRANCH:                     dec.imm = imm_b;
        OPC_LUI, OPC_AUIPC:             dec.imm = imm_u;
        OPC_JAL:                        dec.imm = imm_j;
        default:                        dec.imm = '0;
      endcase
    end
  end

  // Ready depends only on skid occupancy (and reset), never on out_ready.
  assign bus.in_ready = !rst && !skid_v;
  assign accept       = bus.in_valid && bus.in_ready;
  assign consume      = main_v && bus.out_ready;

  // Two-entry FIFO: new words go to main when it is free or draining, else skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (bus.flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (consume) begin
      if (skid_v) begin
        // in_ready is low while skid is full, so no accept can coincide.
        main_q <= skid_q;
        skid_v <= 1'b0;
      end else if (accept) begin
        main_q <= dec;
      end else begin
        main_v <= 1'b0;
      end
    end else if (accept) begin
      if (!main_v) begin
        main_q <= dec;
        main_v <= 1'b1;
      end else begin
        skid_q <= dec;
        skid_v <= 1'b1;
      end
    end
  end

  assign bus.out_valid   = main_v;
  assign bus.out_pc      = main_q.pc;
  assign bus.opcode      = main_q.opcode;
  assign bus.rd          = main_q.rd;
  assign bus.funct3      = main_q.funct3;
  assign bus.rs1         = main_q.rs1;
  assign bus.rs2         = main_q.rs2;
  assign bus.funct7      = main_q.funct7;
  assign bus.imm         = main_q.imm;
  assign bus.is_alu_op   = main_q.is_alu_op;
  assign bus.alu_src_imm = main_q.alu_src_imm;
  assign bus.is_branch   = main_q.is_branch;
  assign bus.is_load     = main_q.is_load;
  assign bus.is_store    = main_q.is_store;
  assign bus.is_jump     = main_q.is_jump;
  assign bus.is_lui      = main_q.is_lui;
  assign bus.is_auipc    = main_q.is_auipc;
  assign bus.is_muldiv   = main_q.is_muldiv;
  assign bus.rd_we       = main_q.rd_we;
  assign bus.illegal     = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a 32-bit instance with the M extension and
// a 64-bit instance without it, driven by one linear sequence of steps.
module tb_decode_stage;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  decode_stage_if #(.XLEN(32)) a ();
  decode_stage_if #(.XLEN(64)) b ();

  decode_stage #(.XLEN(32), .ENABLE_M(1'b1)) u_dut32 (.clk(clk), .rst(rst), .bus(a));
  decode_stage #(.XLEN(64), .ENABLE_M(1'b0)) u_dut64 (.clk(clk), .rst(rst), .bus(b));

  // Clock and reset generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge before checking.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    a.in_valid = v;
    a.in_instr = ins;
    a.in_pc    = pc;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] ins, input logic [63:0] pc);
    b.in_valid = v;
    b.in_instr = ins;
    b.in_pc    = pc;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    a.flush = 1'b0; a.out_ready = 1'b1; drive_a(1'b0, 32'h0, 32'h0);
    b.flush = 1'b0; b.out_ready = 1'b1; drive_b(1'b0, 32'h0, 64'h0);

    // Reset state.
    tick(); tick();
    chk("rst_out_valid", a.out_valid, 0);
    chk("rst_in_ready",  a.in_ready, 0);
    chk("rst_imm",       a.imm, 0);
    chk("rst_out_pc",    a.out_pc, 0);
    chk("rst_rd_we",     a.rd_we, 0);
    chk("rst64_valid",   b.out_valid, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", a.in_ready, 1);
    tick();
    chk("post_rst_ready_clk", a.in_ready, 1);

    // addi x1,x0,-1
    drive_a(1'b1, 32'hFFF00093, 32'h0);
    tick();
    chk("addi_valid",   a.out_valid, 1);
    chk("addi_imm",     a.imm, 64'hFFFFFFFF);
    chk("addi_rd",      a.rd, 1);
    chk("addi_alu",     a.is_alu_op, 1);
    chk("addi_src_imm", a.alu_src_imm, 1);
    chk("addi_rd_we",   a.rd_we, 1);
    chk("addi_illegal", a.illegal, 0);

    // beq x0,x0,-8
    drive_a(1'b1, 32'hFE000CE3, 32'h100);
    tick();
    chk("beq_valid",   a.out_valid, 1);
    chk("beq_imm",     a.imm, 64'hFFFFFFF8);
    chk("beq_branch",  a.is_branch, 1);
    chk("beq_rd_we",   a.rd_we, 0);
    chk("beq_src_imm", a.alu_src_imm, 0);
    chk("beq_pc",      a.out_pc, 64'h100);

    // jalr x1,-4(x2), then the same with funct3=001 (illegal)
    drive_a(1'b1, 32'hFFC100E7, 32'h104);
    tick();
    chk("jalr_imm",  a.imm, 64'hFFFFFFFC);
    chk("jalr_jump", a.is_jump, 1);
    chk("jalr_src",  a.alu_src_imm, 1);
    chk("jalr_we",   a.rd_we, 1);
    drive_a(1'b1, 32'hFFC110E7, 32'h108);
    tick();
    chk("jalr_f3_illegal", a.illegal, 1);
    chk("jalr_f3_imm",     a.imm, 0);
    chk("jalr_f3_jump",    a.is_jump, 0);
    chk("jalr_f3_rd_raw",  a.rd, 1);

    // jal x1,8 ; sw x2,-4(x1) ; branch funct3=010 (illegal)
    drive_a(1'b1, 32'h008000EF, 32'h10C);
    tick();
    chk("jal_imm",  a.imm, 64'h8);
    chk("jal_jump", a.is_jump, 1);
    chk("jal_we",   a.rd_we, 1);
    drive_a(1'b1, 32'hFE20AE23, 32'h110);
    tick();
    chk("sw_imm",   a.imm, 64'hFFFFFFFC);
    chk("sw_store", a.is_store, 1);
    chk("sw_we",    a.rd_we, 0);
    chk("sw_src",   a.alu_src_imm, 1);
    drive_a(1'b1, 32'hFE002CE3, 32'h114);
    tick();
    chk("br010_illegal", a.illegal, 1);
    chk("br010_branch",  a.is_branch, 0);

    // mul x3,x1,x2 with M enabled
    drive_a(1'b1, 32'h022081B3, 32'h118);
    tick();
    chk("mulM_muldiv",  a.is_muldiv, 1);
    chk("mulM_alu",     a.is_alu_op, 1);
    chk("mulM_illegal", a.illegal, 0);
    chk("mulM_rd_we",   a.rd_we, 1);
    drive_a(1'b0, 32'h0, 32'h0);
    tick();
    chk("idle_valid", a.out_valid, 0);

    // Backpressure: A, B, C with out_ready=0.
    a.out_ready = 1'b0;
    drive_a(1'b1, 32'h00100093, 32'h200);
    tick();
    chk("bp_a_valid", a.out_valid, 1);
    chk("bp_a_pc",    a.out_pc, 64'h200);
    chk("bp_ready1",  a.in_ready, 1);
    drive_a(1'b1, 32'h00200113, 32'h204);
    tick();
    chk("bp_ready_full", a.in_ready, 0);
    chk("bp_hold_pc",    a.out_pc, 64'h200);
    drive_a(1'b1, 32'h00300193, 32'h208);
    tick();
    chk("bp_c_blocked", a.in_ready, 0);
    chk("bp_hold_imm",  a.imm, 64'h1);
    chk("bp_hold_pc2",  a.out_pc, 64'h200);
    a.out_ready = 1'b1;
    tick();
    chk("bp_b_pc",    a.out_pc, 64'h204);
    chk("bp_b_imm",   a.imm, 64'h2);
    chk("bp_ready_again", a.in_ready, 1);
    tick();
    chk("bp_c_pc",    a.out_pc, 64'h208);
    chk("bp_c_rd",    a.rd, 3);
    drive_a(1'b0, 32'h0, 32'h0);
    tick();
    chk("bp_drained", a.out_valid, 0);

    // Flush with both entries full and a pending input.
    a.out_ready = 1'b0;
    drive_a(1'b1, 32'h00400213, 32'h300);
    tick();
    drive_a(1'b1, 32'h00500293, 32'h304);
    tick();
    chk("fl_full", a.in_ready, 0);
    drive_a(1'b1, 32'h00600313, 32'h308);
    a.flush = 1'b1;
    tick();
    a.flush = 1'b0;
    drive_a(1'b0, 32'h0, 32'h0);
    chk("fl_valid", a.out_valid, 0);
    chk("fl_ready", a.in_ready, 1);
    a.out_ready = 1'b1;
    tick();
    chk("fl_stay_empty1", a.out_valid, 0);
    tick();
    chk("fl_stay_empty2", a.out_valid, 0);

    // Flush discards an input accepted in the same cycle.
    drive_a(1'b1, 32'h00700393, 32'h30C);
    a.flush = 1'b1;
    tick();
    a.flush = 1'b0;
    drive_a(1'b0, 32'h0, 32'h0);
    chk("fl_acc_valid", a.out_valid, 0);
    tick();
    chk("fl_acc_empty", a.out_valid, 0);

    // 64-bit instance: lui x5,0x80000
    drive_b(1'b1, 32'h800002B7, 64'h1000);
    tick();
    chk("lui64_valid", b.out_valid, 1);
    chk("lui64_imm",   b.imm, 64'hFFFFFFFF80000000);
    chk("lui64_lui",   b.is_lui, 1);
    chk("lui64_rd",    b.rd, 5);
    chk("lui64_pc",    b.out_pc, 64'h1000);

    // mul with M disabled, then the all-zero word.
    drive_b(1'b1, 32'h022081B3, 64'h1004);
    tick();
    chk("mul64_illegal", b.illegal, 1);
    chk("mul64_muldiv",  b.is_muldiv, 0);
    chk("mul64_alu",     b.is_alu_op, 0);
    chk("mul64_rd_we",   b.rd_we, 0);
    chk("mul64_imm",     b.imm, 0);
    chk("mul64_rd_raw",  b.rd, 3);
    drive_b(1'b1, 32'h00000000, 64'h1008);
    tick();
    chk("zero_illegal", b.illegal, 1);
    chk("zero_valid",   b.out_valid, 1);
    drive_b(1'b0, 32'h0, 64'h0);
    tick();
    chk("b_drained", b.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
